// File: rtl/mul16_if.sv
// mul16_if: start/done handshake plus the byte-wide data-memory port of mul16_engine.
interface mul16_if;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    modport master (input start, mem_rd_data, output done, mem_addr, mem_wr_en, mem_wr_data);
    modport slave (output start, mem_rd_data, input done, mem_addr, mem_wr_en, mem_wr_data);
endinterface

// File: rtl/mul16_engine.sv
// mul16_engine: fetches 16 signed 16-bit operand pairs from bytes 0-63, stores big-endian 32-bit products at 64-127.
// Define MUL16_BOOTH4_EN for an 8-cycle radix-4 Booth multiply; default is 16-cycle radix-2 shift-add.
module mul16_engine (
    input  logic    clk,
    input  logic    rst_n,
    mul16_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, MUL, STORE, DONE} state_t;
`ifdef MUL16_BOOTH4_EN
    localparam logic [3:0] MUL_LAST = 4'd7;
`else
    localparam logic [3:0] MUL_LAST = 4'd15;
`endif
    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [3:0]  j_q, j_d, cnt_q, cnt_d;
    logic [31:0] ab_q, ab_d, acc_q, acc_d;
    logic [31:0] mcand, term;
    logic [15:0] mplr_a;
    assign mplr_a = ab_q[31:16];
    assign mcand  = {{16{ab_q[15]}}, ab_q[15:0]};
`ifdef MUL16_BOOTH4_EN
    logic [16:0] mplr_ext;
    logic [2:0]  grp;
    logic [31:0] mag;
    assign mplr_ext = {mplr_a, 1'b0};
    assign grp      = mplr_ext[{cnt_q[2:0], 1'b0} +: 3];
    assign mag      = (grp == 3'b011 || grp == 3'b100) ? (mcand << 1) :
                      (grp == 3'b000 || grp == 3'b111) ? 32'd0 : mcand;
    assign term     = grp[2] ? -(mag << {cnt_q[2:0], 1'b0}) : (mag << {cnt_q[2:0], 1'b0});
`else
    logic [31:0] part;
    assign part = mplr_a[cnt_q] ? (mcand << cnt_q) : 32'd0;
    // bit 15 of the multiplier carries negative weight
    assign term = (cnt_q == 4'd15) ? -part : part;
`endif
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        ab_d    = ab_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (bus.start) armed_d = 1'b1;
                else if (armed_q) begin
                    armed_d = 1'b0;
                    j_d     = 4'd0;
                    cnt_d   = 4'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ab_d  = {ab_q[23:0], bus.mem_rd_data};
                acc_d = 32'd0;
                cnt_d = (cnt_q == 4'd3) ? 4'd0 : cnt_q + 4'd1;
                if (cnt_q == 4'd3) state_d = MUL;
            end
            MUL: begin
                acc_d = acc_q + term;
                cnt_d = (cnt_q == MUL_LAST) ? 4'd0 : cnt_q + 4'd1;
                if (cnt_q == MUL_LAST) state_d = STORE;
            end
            STORE: begin
                cnt_d = (cnt_q == 4'd3) ? 4'd0 : cnt_q + 4'd1;
                if (cnt_q == 4'd3) begin
                    state_d = (j_q == 4'd15) ? DONE : LOAD;
                    j_d     = (j_q == 4'd15) ? j_q : j_q + 4'd1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    armed_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // start going high mid-run abandons the run but leaves the engine armed
        if (bus.start && (state_q == LOAD || state_q == MUL || state_q == STORE)) begin
            state_d = IDLE;
            armed_d = 1'b1;
            cnt_d   = 4'd0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            j_q     <= 4'd0;
            cnt_q   <= 4'd0;
            ab_q    <= 32'd0;
            acc_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            ab_q    <= ab_d;
            acc_q   <= acc_d;
        end
    end
    assign bus.done        = (state_q == DONE);
    assign bus.mem_wr_en   = (state_q == STORE);
    assign bus.mem_addr    = (state_q == LOAD)  ? {2'b00, j_q, cnt_q[1:0]} :
                             (state_q == STORE) ? {2'b01, j_q, cnt_q[1:0]} : 8'd0;
    assign bus.mem_wr_data = (state_q == STORE) ? 8'(acc_q >> {~cnt_q[1:0], 3'b000}) : 8'd0;
endmodule

// File: tb/tb_mul16_engine.sv
// tb_mul16_engine: directed and random checks of mul16_engine against a byte memory model.
`timescale 1ns/1ps
module tb_mul16_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    mul16_if bus();
    mul16_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
    always #5 clk = ~clk;
`ifdef MUL16_BOOTH4_EN
    localparam int M = 8;
`else
    localparam int M = 16;
`endif
    localparam int PAIR = 8 + M;
    localparam int RUN  = 16 * PAIR;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;
    logic [7:0] mem [0:127];
    logic [7:0] init_mem [0:127];
    logic do_init = 1'b0;
    int wr_cnt = 0;
    int oob = 0;
    int checks = 0;
    int errors = 0;
    assign bus.mem_rd_data = bus.mem_addr[7] ? 8'h00 : mem[bus.mem_addr[6:0]];
    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_mem[i];
        end else if (bus.mem_wr_en) begin
            if (bus.mem_addr[7]) oob <= oob + 1;
            else mem[bus.mem_addr[6:0]] <= bus.mem_wr_data;
        end
        if (bus.mem_wr_en) wr_cnt <= wr_cnt + 1;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic clear_init(input logic [7:0] prod_fill);
        for (int i = 0; i < 128; i++) init_mem[i] = (i < 64) ? 8'h00 : prod_fill;
    endtask
    task automatic set_pair(input int j, input logic [15:0] a, input logic [15:0] b);
        init_mem[4*j]   = a[15:8];
        init_mem[4*j+1] = a[7:0];
        init_mem[4*j+2] = b[15:8];
        init_mem[4*j+3] = b[7:0];
    endtask
    task automatic commit();
        @(negedge clk) do_init = 1'b1;
        @(negedge clk) do_init = 1'b0;
    endtask
    task automatic launch();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        @(posedge clk);
    endtask
    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!bus.done && n < 3000);
        chk(name, n, RUN);
    endtask
    function automatic logic [31:0] got(input int j);
        return {mem[64+4*j], mem[65+4*j], mem[66+4*j], mem[67+4*j]};
    endfunction
    task automatic check_model(input string tag, input int npairs);
        logic signed [31:0] p;
        for (int j = 0; j < npairs; j++) begin
            p = $signed({mem[4*j], mem[4*j+1]}) * $signed({mem[4*j+2], mem[4*j+3]});
            chk($sformatf("%s_pair%0d", tag, j), got(j), p);
        end
    endtask
    vec_t tbl [16];
    initial begin
        int bad;
        int w;
        tbl[0]  = '{16'h8000, 16'h8000, 32'h40000000};
        tbl[1]  = '{16'h8000, 16'h0001, 32'hFFFF8000};
        tbl[2]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        tbl[3]  = '{16'h0000, 16'd1234, 32'h00000000};
        tbl[4]  = '{16'd1234, 16'h0000, 32'h00000000};
        tbl[5]  = '{16'hFFFF, 16'hFFFF, 32'h00000001};
        tbl[6]  = '{16'hFFFF, 16'h0001, 32'hFFFFFFFF};
        tbl[7]  = '{16'h0100, 16'h0100, 32'h00010000};
        tbl[8]  = '{16'd100,  16'hFF9C, 32'hFFFFD8F0};
        tbl[9]  = '{16'hFFFE, 16'h4000, 32'hFFFF8000};
        tbl[10] = '{16'd12345, 16'hFFFE, 32'hFFFF9F8E};
        tbl[11] = '{16'h5555, 16'h0003, 32'h0000FFFF};
        tbl[12] = '{16'h7FFF, 16'h8000, 32'hC0008000};
        tbl[13] = '{16'h8000, 16'h7FFF, 32'hC0008000};
        tbl[14] = '{16'h0007, 16'hFFF9, 32'hFFFFFFCF};
        tbl[15] = '{16'hFED4, 16'hFED4, 32'h00015F90};
        bus.start = 1'b0;
        // reset state and no launch without a prior start high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", bus.done, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wr_en", bus.mem_wr_en, 0);
        chk("rst_wr_data", bus.mem_wr_data, 0);
        @(negedge clk) rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (bus.mem_addr != 0 || bus.mem_wr_en || bus.done) bad++;
        end
        chk("no_launch_unarmed", bad, 0);
        // basic run
        clear_init(8'h00);
        set_pair(0, 16'd3, 16'hFFFB);
        commit();
        launch();
        wait_done("basic_latency");
        chk("basic_pair0", got(0), 32'hFFFFFFF1);
        check_model("basic", 16);
        repeat (5) @(posedge clk);
        #1 chk("done_holds", bus.done, 1);
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 chk("done_falls", bus.done, 0);
        // hand-computed table
        clear_init(8'h00);
        for (int j = 0; j < 16; j++) set_pair(j, tbl[j].a, tbl[j].b);
        commit();
        launch();
        wait_done("table_latency");
        for (int j = 0; j < 16; j++) chk($sformatf("table_pair%0d", j), got(j), tbl[j].p);
        // random regression
        for (int r = 0; r < 10; r++) begin
            clear_init(8'h5A);
            for (int j = 0; j < 16; j++) set_pair(j, 16'($urandom), 16'($urandom));
            commit();
            launch();
            wait_done($sformatf("rand%0d_latency", r));
            check_model($sformatf("rand%0d", r), 16);
        end
        // abort during pair 5 MUL
        clear_init(8'hAA);
        for (int j = 0; j < 16; j++) set_pair(j, 16'($urandom), 16'($urandom));
        commit();
        launch();
        repeat (5*PAIR + 6) @(posedge clk);
        @(negedge clk) bus.start = 1'b1;
        repeat (30) @(posedge clk);
        #1 chk("abort_done_low", bus.done, 0);
        chk("abort_idle_wr_en", bus.mem_wr_en, 0);
        check_model("abort", 5);
        bad = 0;
        for (int i = 84; i < 128; i++) if (mem[i] != 8'hAA) bad++;
        chk("abort_untouched", bad, 0);
        @(negedge clk) bus.start = 1'b0;
        @(posedge clk);
        wait_done("rerun_latency");
        check_model("rerun", 16);
        // async reset during STORE
        clear_init(8'h00);
        for (int j = 0; j < 16; j++) set_pair(j, 16'($urandom), 16'($urandom));
        commit();
        launch();
        repeat (4 + M) @(posedge clk);
        #1 chk("store_wr_en", bus.mem_wr_en, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_wr_en", bus.mem_wr_en, 0);
        chk("async_addr", bus.mem_addr, 0);
        w = wr_cnt;
        @(negedge clk) rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1 chk("async_no_writes", wr_cnt, w);
        chk("async_done", bus.done, 0);
        chk("no_oob_writes", oob, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
